// File: rtl/decoder_window_ctrl.sv
// Gamma-window sequencer for a bank of negedge decoders: reload, capture for WINDOW
// cycles, snapshot into a single-entry buffer, then serialise the snapshot line by line.
//
// state   | meaning
// IDLE    | waiting for start or continuous
// CLEAR   | one-cycle reload strobe to the decoder bank
// RUN     | decoders capturing, phase counts 0..WINDOW-1
// CAPTURE | snapshot decoder outputs (or flag overrun if snapshot still full)
module decoder_window_ctrl #(
    parameter int NUM_LINES = 8,
    parameter int VALUE_W   = 8,
    parameter int WINDOW    = 8,
    localparam int IDX_W    = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1,
    localparam int PH_W     = (WINDOW > 1) ? $clog2(WINDOW) : 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           continuous,
    input  logic                           overrun_clear,
    output logic                           dec_clear,
    output logic                           dec_enable,
    input  logic [NUM_LINES*VALUE_W-1:0]   dec_value,
    input  logic [NUM_LINES-1:0]           dec_valid,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [VALUE_W-1:0]             out_data,
    output logic                           out_hit,
    output logic [IDX_W-1:0]               out_index,
    output logic                           out_last,
    output logic                           busy,
    output logic                           overrun
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CLEAR   = 2'd1,
        S_RUN     = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [PH_W-1:0]      phase;
    logic                 phase_last;

    logic [VALUE_W-1:0]   snap_value [NUM_LINES];
    logic [NUM_LINES-1:0] snap_hit;
    logic                 snap_full;
    logic [IDX_W-1:0]     rd_index;
    logic                 rd_last;
    logic                 drain;
    logic                 capture;
    logic                 load_ok;

    assign phase_last = (phase == PH_W'(WINDOW - 1));
    assign rd_last    = (rd_index == IDX_W'(NUM_LINES - 1));
    assign drain      = snap_full && out_ready && rd_last;
    assign capture    = (state == S_CAPTURE);
    // A last-beat transfer in the CAPTURE cycle frees the buffer in time for the new load.
    assign load_ok    = !snap_full || drain;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            phase <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_RUN && !phase_last)
                phase <= phase + 1'b1;
            else
                phase <= '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start || continuous) state_nxt = S_CLEAR;
            S_CLEAR:   state_nxt = S_RUN;
            S_RUN:     if (phase_last) state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = continuous ? S_CLEAR : S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        dec_clear  = (state == S_CLEAR);
        dec_enable = (state == S_RUN);
        busy       = (state != S_IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_LINES; i++) snap_value[i] <= '0;
            snap_hit  <= '0;
            snap_full <= 1'b0;
            rd_index  <= '0;
        end else if (capture && load_ok) begin
            for (int i = 0; i < NUM_LINES; i++)
                snap_value[i] <= dec_value[i*VALUE_W +: VALUE_W];
            snap_hit  <= dec_valid;
            snap_full <= 1'b1;
            rd_index  <= '0;
        end else if (snap_full && out_ready) begin
            if (rd_last) begin
                snap_full <= 1'b0;
                rd_index  <= '0;
            end else begin
                rd_index  <= rd_index + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            overrun <= 1'b0;
        else if (capture && !load_ok)
            overrun <= 1'b1;
        else if (overrun_clear)
            overrun <= 1'b0;
    end

    assign out_valid = snap_full;
    assign out_data  = snap_value[rd_index];
    assign out_hit   = snap_hit[rd_index];
    assign out_index = rd_index;
    assign out_last  = snap_full && rd_last;

endmodule

// File: tb/tb_decoder_window_ctrl.sv
// Directed bench for decoder_window_ctrl: cycle table for a single window plus
// hand-written sequences for backpressure, overrun, continuous mode and reset.
module tb_decoder_window_ctrl;

    localparam int NL = 8;
    localparam int VW = 8;
    localparam int WN = 8;

    logic           clock = 1'b0;
    logic           reset;
    logic           start;
    logic           continuous;
    logic           overrun_clear;
    logic           dec_clear;
    logic           dec_enable;
    logic [NL*VW-1:0] dec_value;
    logic [NL-1:0]  dec_valid;
    logic           out_valid;
    logic           out_ready;
    logic [VW-1:0]  out_data;
    logic           out_hit;
    logic [2:0]     out_index;
    logic           out_last;
    logic           busy;
    logic           overrun;

    int checks   = 0;
    int failures = 0;

    decoder_window_ctrl #(.NUM_LINES(NL), .VALUE_W(VW), .WINDOW(WN)) dut (
        .clock(clock), .reset(reset), .start(start), .continuous(continuous),
        .overrun_clear(overrun_clear), .dec_clear(dec_clear), .dec_enable(dec_enable),
        .dec_value(dec_value), .dec_valid(dec_valid), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_hit(out_hit),
        .out_index(out_index), .out_last(out_last), .busy(busy), .overrun(overrun)
    );

    always #5 clock = ~clock;

    localparam logic [7:0] HIT_A = 8'hA5;
    localparam logic [7:0] HIT_B = 8'h3C;

    typedef struct {
        logic       start;
        logic       ready;
        logic       clr;
        logic       en;
        logic       busy;
        logic       valid;
        logic [7:0] data;
        logic [2:0] idx;
        logic       last;
        logic       hit;
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Pattern A: line i = i+1, hits HIT_A. Pattern B: line i = 0x10+i, hits HIT_B.
    task automatic set_pattern(input bit b);
        for (int i = 0; i < NL; i++)
            dec_value[i*VW +: VW] = b ? 8'(8'h10 + i) : 8'(i + 1);
        dec_valid = b ? HIT_B : HIT_A;
    endtask

    int   exp_line;
    int   clears;
    int   beats;
    int   last_clr;
    int   busy_cycles;
    logic [7:0] hit_tmp;

    initial begin
        reset = 1'b0; start = 1'b0; continuous = 1'b0; overrun_clear = 1'b0;
        out_ready = 1'b0;
        set_pattern(1'b0);

        for (int t = 0; t < 20; t++) begin
            hit_tmp = HIT_A;
            vecs[t].start = (t == 0);
            vecs[t].ready = 1'b1;
            vecs[t].clr   = (t == 0);
            vecs[t].en    = (t >= 1 && t <= 8);
            vecs[t].busy  = (t <= 9);
            vecs[t].valid = (t >= 10 && t <= 17);
            vecs[t].data  = (t >= 10 && t <= 17) ? 8'(t - 9) : 8'd0;
            vecs[t].idx   = (t >= 10 && t <= 17) ? 3'(t - 10) : 3'd0;
            vecs[t].last  = (t == 17);
            vecs[t].hit   = (t >= 10 && t <= 17) ? hit_tmp[t-10] : HIT_A[0];
        end

        repeat (3) tick();
        check("rst_clear", dec_clear, 0);
        check("rst_enable", dec_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_index", out_index, 0);
        #2 reset = 1'b1;
        tick();

        // single window, table driven
        for (int t = 0; t < 20; t++) begin
            start     = vecs[t].start;
            out_ready = vecs[t].ready;
            tick();
            check($sformatf("t1_clr[%0d]", t), dec_clear, vecs[t].clr);
            check($sformatf("t1_en[%0d]", t), dec_enable, vecs[t].en);
            check($sformatf("t1_busy[%0d]", t), busy, vecs[t].busy);
            check($sformatf("t1_valid[%0d]", t), out_valid, vecs[t].valid);
            if (vecs[t].valid) begin
                check($sformatf("t1_data[%0d]", t), out_data, vecs[t].data);
                check($sformatf("t1_idx[%0d]", t), out_index, vecs[t].idx);
                check($sformatf("t1_last[%0d]", t), out_last, vecs[t].last);
                check($sformatf("t1_hit[%0d]", t), out_hit, vecs[t].hit);
            end
        end
        start = 1'b0;

        // backpressure
        out_ready = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        for (int n = 0; n < 30 && !out_valid; n++) tick();
        check("t2_valid_wait", out_valid, 1);
        for (int n = 0; n < 5; n++) begin
            check("t2_hold_data", out_data, 1);
            check("t2_hold_idx", out_index, 0);
            tick();
        end
        exp_line = 0;
        for (int c = 0; c < 40 && exp_line < NL; c++) begin
            out_ready = (c % 2 == 0);
            #1;
            if (out_valid && out_ready) begin
                check("t2_data", out_data, exp_line + 1);
                check("t2_idx", out_index, exp_line);
                check("t2_last", out_last, exp_line == NL - 1);
                exp_line++;
            end
            tick();
        end
        out_ready = 1'b0;
        check("t2_beats", exp_line, NL);
        check("t2_empty", out_valid, 0);

        // overrun with continuous and no ready
        set_pattern(1'b0);
        continuous = 1'b1;
        for (int n = 0; n < 30 && !out_valid; n++) tick();
        check("t3_valid_wait", out_valid, 1);
        set_pattern(1'b1);
        for (int n = 0; n < 30 && !overrun; n++) tick();
        check("t3_overrun_set", overrun, 1);
        check("t3_keep_data", out_data, 1);
        check("t3_keep_hit", out_hit, HIT_A[0]);
        check("t3_keep_idx", out_index, 0);
        continuous = 1'b0;
        for (int n = 0; n < 30 && busy; n++) tick();
        check("t3_idle", busy, 0);
        check("t3_overrun_sticky", overrun, 1);
        overrun_clear = 1'b1; tick(); overrun_clear = 1'b0;
        check("t3_overrun_clr", overrun, 0);
        out_ready = 1'b1;
        repeat (NL) tick();
        out_ready = 1'b0;
        check("t3_drained", out_valid, 0);

        // last-beat transfer coincides with CAPTURE: load, no overrun
        set_pattern(1'b0);
        continuous = 1'b1;
        for (int n = 0; n < 30 && !out_valid; n++) tick();
        check("t3b_valid_wait", out_valid, 1);
        set_pattern(1'b1);
        for (int n = 0; n < 30 && !dec_enable; n++) tick();
        check("t3b_run_wait", dec_enable, 1);
        continuous = 1'b0;
        tick();
        out_ready = 1'b1;
        repeat (NL) tick();
        out_ready = 1'b0;
        check("t3b_full", out_valid, 1);
        check("t3b_new_data", out_data, 8'h10);
        check("t3b_new_hit", out_hit, HIT_B[0]);
        check("t3b_idx", out_index, 0);
        check("t3b_no_overrun", overrun, 0);
        out_ready = 1'b1;
        repeat (NL) tick();
        out_ready = 1'b0;
        check("t3b_drained", out_valid, 0);

        // back-to-back continuous windows
        set_pattern(1'b0);
        continuous = 1'b1; out_ready = 1'b1;
        clears = 0; beats = 0; last_clr = -1;
        for (int c = 0; c < 80; c++) begin
            if (c == 45) continuous = 1'b0;
            if (dec_clear) begin
                if (last_clr >= 0) check("t4_clr_period", c - last_clr, WN + 2);
                last_clr = c;
                clears++;
            end
            if (out_valid && out_ready) begin
                check("t4_beat_data", out_data, (beats % NL) + 1);
                beats++;
            end
            check("t4_no_overrun", overrun, 0);
            tick();
        end
        out_ready = 1'b0;
        check("t4_idle", busy, 0);
        check("t4_drained", out_valid, 0);
        check("t4_beats", beats, NL * clears);
        check("t4_windows", clears >= 4, 1);

        // async reset at RUN phase 3
        start = 1'b1; tick(); start = 1'b0;
        for (int n = 0; n < 10 && !dec_enable; n++) tick();
        check("t5_run_wait", dec_enable, 1);
        repeat (3) tick();
        check("t5_still_run", dec_enable, 1);
        reset = 1'b0;
        #1;
        check("t5_enable_drop", dec_enable, 0);
        check("t5_busy_drop", busy, 0);
        check("t5_valid_drop", out_valid, 0);
        #2 reset = 1'b1;
        busy_cycles = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (busy || dec_clear) busy_cycles++;
        end
        check("t5_stays_idle", busy_cycles, 0);

        // async reset mid-readout discards the snapshot
        start = 1'b1; tick(); start = 1'b0;
        for (int n = 0; n < 30 && !out_valid; n++) tick();
        check("t5b_valid_wait", out_valid, 1);
        reset = 1'b0;
        #1;
        check("t5b_valid_drop", out_valid, 0);
        #2 reset = 1'b1;
        tick();
        check("t5b_empty", out_valid, 0);
        check("t5b_idle", busy, 0);

        // start during RUN is ignored
        out_ready = 1'b1;
        clears = 0; beats = 0;
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            start = (c == 3);
            if (c == 3) check("t6_in_run", dec_enable, 1);
            if (dec_clear) clears++;
            if (out_valid && out_ready) beats++;
            tick();
        end
        start = 1'b0;
        check("t6_one_window", clears, 1);
        check("t6_beats", beats, NL);
        check("t6_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
